// File: rtl/parking_occupancy_pkg.sv
// Shared parking-lot widths, limits and the count-to-BCD split used by the display path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package parking_occupancy_pkg;

    localparam int COUNT_W          = 7;
    localparam int BCD_W            = 4;
    localparam int MAX_CAPACITY     = 99;
    localparam int DEFAULT_CAPACITY = 20;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_t;

    // Only meaningful for 0..99, which the counter never leaves.
    function automatic bcd_t count_to_bcd(input logic [COUNT_W-1:0] bin);
        bcd_t d;
        d.tens = BCD_W'(bin / COUNT_W'(10));
        d.ones = BCD_W'(bin % COUNT_W'(10));
        return d;
    endfunction

endpackage

// File: rtl/parking_occupancy_bcd.sv
// Registered binary-to-BCD split of the occupancy count for the lot display.
// Latency: 1 cycle from bin to tens/ones.
// Backpressure: none; a new value is taken every cycle.
module occupancy_bcd
    import parking_occupancy_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] bin,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones
);

    bcd_t digits;

    assign digits = count_to_bcd(bin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else begin
            tens <= digits.tens;
            ones <= digits.ones;
        end
    end

endmodule

// File: rtl/parking_occupancy.sv
// Saturating lot occupancy counter with full/empty status, sticky error flags and BCD digits.
// Latency: count/full/empty/errors 1 cycle after a pulse; BCD digits one cycle behind count.
// Backpressure: none; every pulse is taken, surplus entries/exits only raise error flags.
module parking_occupancy
    import parking_occupancy_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entering,
    input  logic               exiting,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               over_err,
    output logic               under_err,
    output logic [BCD_W-1:0]   bcd_tens,
    output logic [BCD_W-1:0]   bcd_ones
);

    generate
        if (CAPACITY < 1 || CAPACITY > MAX_CAPACITY) begin : g_bad_capacity
            $error("parking_occupancy: CAPACITY must be within 1..99");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

    logic [COUNT_W-1:0] count_nxt;
    logic               over_nxt;
    logic               under_nxt;

    // Simultaneous entry and exit cancel out and are not errors.
    always_comb begin
        count_nxt = count;
        over_nxt  = over_err;
        under_nxt = under_err;
        if (clear) begin
            count_nxt = '0;
            over_nxt  = 1'b0;
            under_nxt = 1'b0;
        end else if (entering && !exiting) begin
            if (count == CAP_C) over_nxt = 1'b1;
            else                count_nxt = count + COUNT_W'(1);
        end else if (exiting && !entering) begin
            if (count == '0) under_nxt = 1'b1;
            else             count_nxt = count - COUNT_W'(1);
        end
    end

    // full/empty come from the next count so they move on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            over_err  <= 1'b0;
            under_err <= 1'b0;
        end else begin
            count     <= count_nxt;
            full      <= (count_nxt == CAP_C);
            empty     <= (count_nxt == '0);
            over_err  <= over_nxt;
            under_err <= under_nxt;
        end
    end

    occupancy_bcd u_bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (count),
        .tens  (bcd_tens),
        .ones  (bcd_ones)
    );

endmodule

// File: doc/parking_occupancy.md
PARKING_OCCUPANCY -- requirements
Module: parking_occupancy

Interface
REQ-001 Parameter CAPACITY, 20, number of spaces in the lot; legal range 1..99.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 entering  input  1  one-cycle pulse from the gate sensor FSM; one car has entered.
REQ-005 exiting  input  1  one-cycle pulse from the gate sensor FSM; one car has left.
REQ-006 clear  input  1  synchronous clear of count and error flags.
REQ-007 count  output  7  registered number of occupied spaces, unsigned binary.
REQ-008 full  output  1  registered; high when count == CAPACITY.
REQ-009 empty  output  1  registered; high when count == 0.
REQ-010 over_err  output  1  sticky; an entry was seen while full.
REQ-011 under_err  output  1  sticky; an exit was seen while empty.
REQ-012 bcd_tens  output  4  registered BCD tens digit of count, for the lot display.
REQ-013 bcd_ones  output  4  registered BCD ones digit of count.

Function
REQ-014 entering=1, exiting=0, count<CAPACITY: count increments by 1 on the next edge.
REQ-015 entering=0, exiting=1, count>0: count decrements by 1 on the next edge.
REQ-016 entering=1 and exiting=1 in the same cycle: count is unchanged and no error flag sets.
REQ-017 Entry while count==CAPACITY: count holds (saturates) and over_err sets on the next edge.
REQ-018 Exit while count==0: count holds at 0 and under_err sets on the next edge.
REQ-019 over_err and under_err stay high until clear or reset.
REQ-020 full and empty are registered from the next-count value, so they change on the same edge as count (zero cycles of skew).
REQ-021 count never exceeds CAPACITY and never wraps below 0.
REQ-022 bcd_tens/bcd_ones reflect count with exactly one cycle of latency: both digits change on the edge after count changes.
REQ-023 BCD conversion uses a registered stage: tens = count/10, ones = count mod 10, valid for 0..99.
REQ-024 clear=1: count=0, empty=1, full=0, and both error flags clear on the next edge.
REQ-025 clear has priority over entering/exiting in the same cycle; pulses in that cycle are discarded.
REQ-026 Input pulses longer than one cycle are counted once per cycle high; no edge detection is done in this block.

Reset
REQ-027 reset=1 asynchronously forces count=0, full=0, empty=1, over_err=0, under_err=0, bcd_tens=0, bcd_ones=0.
REQ-028 Reset asserted mid-operation discards any pulse in that cycle; counting resumes on the first edge after deassertion.
REQ-029 Reset deassertion is synchronous to clk in the parent; this block adds no synchronizer.

Structure
REQ-030 The shared parking package holds COUNT_W=7, BCD_W=4, MAX_CAPACITY=99, and the default CAPACITY.
REQ-031 BCD conversion lives in one sub-module, occupancy_bcd: 7-bit in, two 4-bit digits out, registered, with the same clk/reset.
REQ-032 The counter, flags and error logic stay in parking_occupancy; there is no FSM beyond the count register.
REQ-033 An elaboration-time check rejects CAPACITY<1 or CAPACITY>99.

Verification
REQ-034 After reset, pulse entering 3 times -> count=3, empty=0, full=0; digits read 0/3 one cycle later.
REQ-035 CAPACITY=20; 20 entries then 1 more -> count stays 20, full=1, over_err=1.
REQ-036 From reset, one exiting pulse -> count=0, empty=1, under_err=1; clear -> under_err=0.
REQ-037 count=5; entering=1 and exiting=1 together for 4 cycles -> count=5, no error flags.
REQ-038 count=12; raise reset between edges -> all outputs 0 immediately and empty=1; digits 0/0.
REQ-039 count=9; one entry -> count=10 on edge N; bcd_tens=1, bcd_ones=0 on edge N+1.
